// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: register-file write payload and source select.
package wb_arbiter_pkg;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        we;
        logic [31:0] instruction;
        logic [31:0] pc;
    } wb_payload_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_MULT,
        SRC_BUF,
        SRC_ALU
    } wb_src_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Result buses from mult5 and the ALU into writeback, and the register-file write port out.
interface wb_arbiter_if;

    logic [31:0] mult5_int_write_data_i;
    logic [4:0]  mult5_write_addr_i;
    logic        mult5_int_write_enable_i;
    logic [31:0] mult5_instruction_i;
    logic [31:0] mult5_pc_i;

    logic [31:0] alu_int_write_data_i;
    logic [4:0]  alu_write_addr_i;
    logic        alu_int_write_enable_i;
    logic [31:0] alu_instruction_i;
    logic [31:0] alu_pc_i;

    logic [31:0] rf_write_data_o;
    logic [4:0]  rf_write_addr_o;
    logic        rf_write_enable_o;
    logic [31:0] wb_instruction_o;
    logic [31:0] wb_pc_o;
    logic        alu_stall_o;

    modport slave (
        input  mult5_int_write_data_i, mult5_write_addr_i, mult5_int_write_enable_i,
               mult5_instruction_i, mult5_pc_i,
        input  alu_int_write_data_i, alu_write_addr_i, alu_int_write_enable_i,
               alu_instruction_i, alu_pc_i,
        output rf_write_data_o, rf_write_addr_o, rf_write_enable_o,
               wb_instruction_o, wb_pc_o, alu_stall_o
    );

    modport master (
        output mult5_int_write_data_i, mult5_write_addr_i, mult5_int_write_enable_i,
               mult5_instruction_i, mult5_pc_i,
        output alu_int_write_data_i, alu_write_addr_i, alu_int_write_enable_i,
               alu_instruction_i, alu_pc_i,
        input  rf_write_data_o, rf_write_addr_o, rf_write_enable_o,
               wb_instruction_o, wb_pc_o, alu_stall_o
    );

endinterface

// File: rtl/wb_skid_fifo.sv
// In-order skid buffer for ALU results that lost arbitration; flush empties it in one edge.
// Squash clears the write enable of every live entry targeting the given register.
module wb_skid_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    localparam int PW = $clog2(BUF_DEPTH)
) (
    input  logic        clk_i,
    input  logic        rsn_i,
    input  logic        flush_i,
    input  logic        push_i,
    input  wb_payload_t push_dat_i,
    input  logic        pop_i,
    input  logic        squash_vld_i,
    input  logic [4:0]  squash_addr_i,
    output wb_payload_t head_dat_o,
    output logic [PW:0] count_o,
    output logic        full_o
);

    wb_payload_t   mem_q [BUF_DEPTH];
    wb_payload_t   mem_d [BUF_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;

    always_comb begin
        logic [PW-1:0] ofs;
        ofs      = '0;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Only entries between head and tail are live; stale slots are left alone.
            if (squash_vld_i) begin
                for (int i = 0; i < BUF_DEPTH; i++) begin
                    ofs = PW'(i) - rd_ptr_q;
                    if (({1'b0, ofs} < count_q) && (mem_q[i].addr == squash_addr_i)) begin
                        mem_d[i].we = 1'b0;
                    end
                end
            end
            if (push_i) begin
                mem_d[wr_ptr_q] = push_dat_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign full_o     = (count_q == (PW+1)'(BUF_DEPTH));

endmodule

// File: rtl/wb_arbiter.sv
// Merges mult5 and ALU results onto the register-file write port, one cycle registered.
// mult5 wins; displaced ALU results queue in order and the ALU is stalled while the queue is full.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rsn_i,
    input  logic         kill_i,
    wb_arbiter_if.slave  wb
);

    localparam int PW = $clog2(BUF_DEPTH);

    wb_payload_t mult_pl, alu_pl, head_pl, sel_pl;
    wb_payload_t out_q, out_d;
    wb_src_e     src;
    logic [PW:0] buf_count;
    logic        buf_full;
    logic        alu_acc;
    logic        push, pop, squash_vld;

    assign mult_pl = '{data: wb.mult5_int_write_data_i, addr: wb.mult5_write_addr_i, we: 1'b1,
                       instruction: wb.mult5_instruction_i, pc: wb.mult5_pc_i};
    assign alu_pl  = '{data: wb.alu_int_write_data_i, addr: wb.alu_write_addr_i, we: 1'b1,
                       instruction: wb.alu_instruction_i, pc: wb.alu_pc_i};

    assign alu_acc = wb.alu_int_write_enable_i && !buf_full;

    always_comb begin
        src    = SRC_NONE;
        sel_pl = '0;
        if (wb.mult5_int_write_enable_i) begin
            src = SRC_MULT;
        end else if (buf_count != '0) begin
            src = SRC_BUF;
        end else if (alu_acc) begin
            src = SRC_ALU;
        end
        case (src)
            SRC_MULT: sel_pl = mult_pl;
            SRC_BUF:  sel_pl = head_pl;
            SRC_ALU:  sel_pl = alu_pl;
            default:  sel_pl = '0;
        endcase
        out_d = sel_pl;
        if (sel_pl.addr == REG_X0) begin
            out_d.we = 1'b0;
        end
        if (kill_i) begin
            out_d = '0;
        end
    end

    // A buffered older result for the same register must not overwrite mult5's newer one.
    assign squash_vld = wb.mult5_int_write_enable_i && (wb.mult5_write_addr_i != REG_X0);
    assign push       = alu_acc && (src != SRC_ALU);
    assign pop        = (src == SRC_BUF);

    wb_skid_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_skid (
        .clk_i         (clk_i),
        .rsn_i         (rsn_i),
        .flush_i       (kill_i),
        .push_i        (push),
        .push_dat_i    (alu_pl),
        .pop_i         (pop),
        .squash_vld_i  (squash_vld),
        .squash_addr_i (wb.mult5_write_addr_i),
        .head_dat_o    (head_pl),
        .count_o       (buf_count),
        .full_o        (buf_full)
    );

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign wb.rf_write_data_o   = out_q.data;
    assign wb.rf_write_addr_o   = out_q.addr;
    assign wb.rf_write_enable_o = out_q.we;
    assign wb.wb_instruction_o  = out_q.instruction;
    assign wb.wb_pc_o           = out_q.pc;
    assign wb.alu_stall_o       = buf_full;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomized bench for wb_arbiter against a queue-based reference of the writeback rules.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int DEPTH = 2;

    logic clk_i = 1'b0;
    logic rsn_i;
    logic kill_i;

    always #5 clk_i = ~clk_i;

    wb_arbiter_if bus ();

    wb_arbiter #(.BUF_DEPTH(DEPTH)) dut (
        .clk_i  (clk_i),
        .rsn_i  (rsn_i),
        .kill_i (kill_i),
        .wb     (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    wb_payload_t q[$];
    wb_payload_t exp_out;
    bit          alu_pending;
    logic [31:0] pc_ctr;
    logic [31:0] last_alu_pc;
    logic [31:0] saved_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string ctx);
        chk({ctx, ".data"},  bus.rf_write_data_o,           exp_out.data);
        chk({ctx, ".addr"},  32'(bus.rf_write_addr_o),      32'(exp_out.addr));
        chk({ctx, ".we"},    32'(bus.rf_write_enable_o),    32'(exp_out.we));
        chk({ctx, ".instr"}, bus.wb_instruction_o,          exp_out.instruction);
        chk({ctx, ".pc"},    bus.wb_pc_o,                   exp_out.pc);
    endtask

    // Called at a falling edge: check last edge's result, drive this cycle, predict the next result.
    task automatic step(input bit mw, input logic [4:0] ma, input logic [31:0] md,
                        input bit aw, input logic [4:0] aa, input logic [31:0] ad, input bit k);
        wb_payload_t mp, ap;
        bit          stall_m, acc;
        check_out("cycle");
        stall_m = (q.size() == DEPTH);
        chk("stall", 32'(bus.alu_stall_o), 32'(stall_m));
        kill_i = k;
        bus.mult5_int_write_enable_i = mw;
        bus.mult5_write_addr_i       = ma;
        bus.mult5_int_write_data_i   = md;
        bus.mult5_instruction_i      = $urandom;
        bus.mult5_pc_i               = pc_ctr;
        pc_ctr += 32'd4;
        if (!alu_pending) begin
            bus.alu_int_write_enable_i = aw;
            bus.alu_write_addr_i       = aa;
            bus.alu_int_write_data_i   = ad;
            bus.alu_instruction_i      = $urandom;
            bus.alu_pc_i               = pc_ctr;
            pc_ctr += 32'd4;
        end
        last_alu_pc = bus.alu_pc_i;
        mp = '{data: bus.mult5_int_write_data_i, addr: bus.mult5_write_addr_i, we: 1'b1,
               instruction: bus.mult5_instruction_i, pc: bus.mult5_pc_i};
        ap = '{data: bus.alu_int_write_data_i, addr: bus.alu_write_addr_i, we: 1'b1,
               instruction: bus.alu_instruction_i, pc: bus.alu_pc_i};
        acc = bus.alu_int_write_enable_i && !stall_m;
        if (k) begin
            q.delete();
            exp_out     = '0;
            alu_pending = 1'b0;
        end else begin
            alu_pending = bus.alu_int_write_enable_i && stall_m;
            if (mw) begin
                if (ma != 5'd0) begin
                    foreach (q[i]) if (q[i].addr == ma) q[i].we = 1'b0;
                end
                exp_out = mp;
                if (acc) q.push_back(ap);
            end else if (q.size() > 0) begin
                exp_out = q.pop_front();
                if (acc) q.push_back(ap);
            end else if (acc) begin
                exp_out = ap;
            end else begin
                exp_out = '0;
            end
            if (exp_out.addr == 5'd0) exp_out.we = 1'b0;
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    initial begin
        rsn_i       = 1'b0;
        kill_i      = 1'b0;
        pc_ctr      = 32'h0000_1000;
        last_alu_pc = '0;
        saved_pc    = '0;
        alu_pending = 1'b0;
        exp_out     = '0;
        bus.mult5_int_write_enable_i = 1'b0;
        bus.mult5_write_addr_i       = '0;
        bus.mult5_int_write_data_i   = '0;
        bus.mult5_instruction_i      = '0;
        bus.mult5_pc_i               = '0;
        bus.alu_int_write_enable_i   = 1'b0;
        bus.alu_write_addr_i         = '0;
        bus.alu_int_write_data_i     = '0;
        bus.alu_instruction_i        = '0;
        bus.alu_pc_i                 = '0;

        #2;
        check_out("reset");
        chk("reset.stall", 32'(bus.alu_stall_o), 32'd0);
        @(negedge clk_i);
        rsn_i = 1'b1;
        @(negedge clk_i);

        // ALU alone goes straight through
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11, 1'b0);
        chk("alu_only.addr", 32'(bus.rf_write_addr_o), 32'd5);
        chk("alu_only.data", bus.rf_write_data_o, 32'h11);
        chk("alu_only.we", 32'(bus.rf_write_enable_o), 32'd1);
        chk("alu_only.stall", 32'(bus.alu_stall_o), 32'd0);

        // Collision: mult5 first, ALU next cycle
        step(1'b1, 5'd3, 32'hAA, 1'b1, 5'd4, 32'hBB, 1'b0);
        chk("collide.c1.addr", 32'(bus.rf_write_addr_o), 32'd3);
        chk("collide.c1.data", bus.rf_write_data_o, 32'hAA);
        idle();
        chk("collide.c2.addr", 32'(bus.rf_write_addr_o), 32'd4);
        chk("collide.c2.data", bus.rf_write_data_o, 32'hBB);
        chk("collide.c2.we", 32'(bus.rf_write_enable_o), 32'd1);
        idle();

        // Full buffer: x6,x7 queue, x8 held upstream, order preserved
        step(1'b1, 5'd1, 32'h100, 1'b1, 5'd6, 32'h66, 1'b0);
        step(1'b1, 5'd2, 32'h200, 1'b1, 5'd7, 32'h77, 1'b0);
        chk("full.stall", 32'(bus.alu_stall_o), 32'd1);
        step(1'b1, 5'd3, 32'h300, 1'b1, 5'd8, 32'h88, 1'b0);
        step(1'b1, 5'd4, 32'h400, 1'b1, 5'd8, 32'h88, 1'b0);
        step(1'b0, 5'd0, 32'd0,   1'b1, 5'd8, 32'h88, 1'b0);
        chk("full.order0", 32'(bus.rf_write_addr_o), 32'd6);
        step(1'b0, 5'd0, 32'd0,   1'b1, 5'd8, 32'h88, 1'b0);
        chk("full.order1", 32'(bus.rf_write_addr_o), 32'd7);
        step(1'b0, 5'd0, 32'd0,   1'b1, 5'd9, 32'h99, 1'b0);
        chk("full.order2", 32'(bus.rf_write_addr_o), 32'd8);
        idle();
        chk("full.order3", 32'(bus.rf_write_addr_o), 32'd9);
        idle();

        // WAW squash of a buffered older x7
        step(1'b1, 5'd1, 32'h5, 1'b1, 5'd7, 32'h1, 1'b0);
        saved_pc = last_alu_pc;
        step(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("waw.mult.data", bus.rf_write_data_o, 32'h2);
        chk("waw.mult.we", 32'(bus.rf_write_enable_o), 32'd1);
        idle();
        chk("waw.squashed.we", 32'(bus.rf_write_enable_o), 32'd0);
        chk("waw.squashed.pc", bus.wb_pc_o, saved_pc);
        idle();

        // Kill with two buffered entries
        step(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'hA0, 1'b0);
        step(1'b1, 5'd2, 32'h2, 1'b1, 5'd11, 32'hB0, 1'b0);
        step(1'b1, 5'd3, 32'h3, 1'b1, 5'd12, 32'hC0, 1'b1);
        chk("kill.we", 32'(bus.rf_write_enable_o), 32'd0);
        chk("kill.data", bus.rf_write_data_o, 32'd0);
        chk("kill.pc", bus.wb_pc_o, 32'd0);
        chk("kill.stall", 32'(bus.alu_stall_o), 32'd0);
        idle();
        chk("kill.after.we", 32'(bus.rf_write_enable_o), 32'd0);

        // Write to x0 is suppressed but traced
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF, 1'b0);
        chk("x0.we", 32'(bus.rf_write_enable_o), 32'd0);
        chk("x0.pc", bus.wb_pc_o, last_alu_pc);
        idle();

        // Reset asserted between edges while traffic is flowing
        step(1'b1, 5'd1, 32'h1, 1'b1, 5'd14, 32'hE0, 1'b0);
        step(1'b1, 5'd2, 32'h2, 1'b1, 5'd15, 32'hF0, 1'b0);
        rsn_i = 1'b0;
        #1;
        chk("rst_mid.we", 32'(bus.rf_write_enable_o), 32'd0);
        chk("rst_mid.stall", 32'(bus.alu_stall_o), 32'd0);
        q.delete();
        exp_out     = '0;
        alu_pending = 1'b0;
        check_out("rst_mid");
        @(negedge clk_i);
        rsn_i = 1'b1;
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'hD0, 1'b0);
        chk("rst_mid.first.addr", 32'(bus.rf_write_addr_o), 32'd13);
        chk("rst_mid.first.we", 32'(bus.rf_write_enable_o), 32'd1);

        // Randomized traffic against the reference queue
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 39) == 0));
        end
        for (int n = 0; n < 4; n++) idle();
        check_out("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-stage consumer of the mult5 result interface and the single-cycle ALU result interface.
- Merges both onto the single register-file write port.
- mult5 always has priority. ALU results that lose arbitration wait in a small in-order skid buffer.
- Back-pressure to the ALU path uses alu_stall_o. Preserves write-after-write order on the register file.

Parameters:
- BUF_DEPTH, 2, number of ALU result entries held while mult5 owns the write port (power of 2, ≥2)

Ports:
- clk_i  in  1  core clock
- rsn_i  in  1  reset, asynchronous, active-low
- kill_i  in  1  pipeline flush; drops buffered and in-flight results
- mult5_int_write_data_i  in  32  mult result
- mult5_write_addr_i  in  5  mult destination register
- mult5_int_write_enable_i  in  1  mult result valid
- mult5_instruction_i  in  32  mult instruction word
- mult5_pc_i  in  32  mult PC
- alu_int_write_data_i  in  32  ALU result
- alu_write_addr_i  in  5  ALU destination register
- alu_int_write_enable_i  in  1  ALU result valid
- alu_instruction_i  in  32  ALU instruction word
- alu_pc_i  in  32  ALU PC
- rf_write_data_o  out  32  register-file write data
- rf_write_addr_o  out  5  register-file write address
- rf_write_enable_o  out  1  register-file write strobe
- wb_instruction_o  out  32  retiring instruction (trace/debug)
- wb_pc_o  out  32  retiring PC
- alu_stall_o  out  1  ALU path must hold its result this cycle

Behaviour:
- Reset:
  - Asserting rsn_i low immediately clears all outputs to 0 and empties the buffer (count=0, rd/wr pointers=0), regardless of clock.
- Output registers:
  - All rf_*/wb_* outputs are registered. Latency from input to rf_* is 1 cycle.
- Source select, evaluated each cycle in priority order:
  - (1) mult5, if mult5_int_write_enable_i=1;
  - (2) otherwise the buffer head, if count>0;
  - (3) otherwise the ALU input, if alu_int_write_enable_i=1 and alu_stall_o=0;
  - (4) otherwise write enable is 0. Data, address, instruction and PC outputs are zeroed when idle.
- Push rule:
  - An accepted ALU result (enable=1, stall=0) not selected this cycle is pushed at the buffer tail.
  - Whenever count>0, ALU results must be pushed, never bypassed, to keep program order.
- Pop rule:
  - The head is popped when it is selected.
  - Push and pop in the same cycle leave count unchanged.
- Stall:
  - alu_stall_o = (count==BUF_DEPTH), combinational from the count register.
  - While stalled, ALU inputs are ignored; the upstream latch holds them.
- WAW squash:
  - When mult5 writes address R≠0, every valid buffered entry whose addr==R has its write enable cleared.
  - Reason: that entry is older but would otherwise land later.
  - A squashed entry still drains in order, retires with rf_write_enable_o=0, and still presents its instruction/PC.
- x0:
  - rf_write_enable_o is forced to 0 whenever the selected address is 0.
  - Instruction and PC still pass through.
- Kill:
  - kill_i=1 at a clock edge empties the buffer, zeroes all outputs and drops that cycle's inputs. This overrides every other action.
  - alu_stall_o drops the cycle after the kill.
- Pointers:
  - Rd/wr pointers are log2(BUF_DEPTH) bits and wrap modulo BUF_DEPTH.
  - Count is log2(BUF_DEPTH)+1 bits.

Decomposition:
- Shared package: the writeback payload struct {data[31:0], addr[4:0], we, instruction[31:0], pc[31:0]}, plus a REG_X0 constant (5'd0).
- One natural sub-module: wb_skid_fifo. It is a BUF_DEPTH-entry payload FIFO with push/pop/flush, count and full outputs, and an addr-match squash input.
- The arbiter keeps the select mux, the x0 masking and the output registers.

Test Plan:
- Reset mid-traffic:
  - Stimulus: drive mult5 and ALU valid, pull rsn_i low between clock edges.
  - Response: rf_write_enable_o=0 and alu_stall_o=0 immediately; after release the first write appears 1 cycle after the next valid input.
- ALU only:
  - Stimulus: alu x5=0x11 at cycle 0.
  - Response: cycle 1 shows rf_write_addr_o=5, data 0x11, we=1, buffer stays empty.
- Collision:
  - Stimulus: mult5 x3=0xAA and alu x4=0xBB at cycle 0; idle at cycle 1.
  - Response: cycle 1 writes x3=0xAA; cycle 2 writes x4=0xBB.
- Full buffer:
  - Stimulus: mult5 valid for 4 cycles while ALU offers x6..x9; BUF_DEPTH=2.
  - Response: alu_stall_o=1 from cycle 2. x6 and x7 are buffered and x8 is held upstream. After mult5 goes idle, writes follow order x6, x7, x8, x9.
- WAW squash:
  - Stimulus: buffer holds alu x7=0x1; mult5 writes x7=0x2.
  - Response: x7 ends at 0x2; the buffered entry retires with we=0 and its PC shown on wb_pc_o.
- Kill with 2 buffered entries:
  - Stimulus: assert kill_i for 1 cycle.
  - Response: no further rf writes from those entries, outputs all 0, alu_stall_o=0 the next cycle.
- x0 write:
  - Stimulus: alu x0=0xFF.
  - Response: rf_write_enable_o=0, wb_pc_o=alu_pc_i.
